note_stream_collector: RTL and testbench

- Receive end of the serial note-position stream. The sender presents one 10-bit x position per clock, tagged with a running index. Index 0 means idle or reset; index k (1..N) carries slot k-1. The sender saturates at index N.
- This block rebuilds the N slots into a parallel, double-buffered bank. It raises a one-cycle frame_valid when a full, in-order frame has been committed.
- It sits between the note-position serializer and the note render/compare logic, which needs a stable parallel snapshot.

---
 rtl/note_stream_collector.sv | 167 ++++++++++++++++
 tb/tb_note_stream_collector.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/note_stream_collector.sv
// Rebuilds the indexed serial note-position stream into a double-buffered parallel bank.
// Optional running min/max of each committed frame is enabled with NOTE_MINMAX_EN.
module note_stream_collector #(
    parameter int unsigned N_NOTES = 32,
    parameter int unsigned W       = 10,
    parameter int unsigned IDX_W   = 6
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [W-1:0]         x_in,
    input  logic [IDX_W-1:0]     idx_in,
    output logic [N_NOTES*W-1:0] x_bank,
    output logic                 frame_valid,
    output logic                 busy,
    output logic                 seq_err,
    output logic [7:0]           frame_cnt,
    output logic [W-1:0]         x_min,
    output logic [W-1:0]         x_max
);

    typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT, HOLD} state_t;

    localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);
    localparam logic [IDX_W-1:0] TWO_IDX   = IDX_W'(2);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_NOTES);
    // A single-slot frame is complete as soon as slot 0 lands.
    localparam state_t           FIRST_NXT = (N_NOTES == 1) ? COMMIT : CAPTURE;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] expected, expected_nxt;
    logic             cap_en;
    logic [IDX_W-1:0] cap_slot;
    logic             err_set;
    logic             commit;
    logic [W-1:0]     shadow [N_NOTES];

    // Next-state, capture strobe and error detection.
    always_comb begin
        state_nxt    = state;
        expected_nxt = expected;
        cap_en       = 1'b0;
        cap_slot     = '0;
        err_set      = 1'b0;
        case (state)
            IDLE: begin
                if (idx_in == ONE_IDX) begin
                    cap_en       = 1'b1;
                    expected_nxt = TWO_IDX;
                    state_nxt    = FIRST_NXT;
                end
            end
            CAPTURE: begin
                if (idx_in == '0) begin
                    state_nxt = IDLE;
                end else if (idx_in == expected) begin
                    cap_en       = 1'b1;
                    cap_slot     = idx_in - ONE_IDX;
                    expected_nxt = expected + ONE_IDX;
                    if (idx_in == LAST_IDX) begin
                        state_nxt = COMMIT;
                    end
                end else begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            COMMIT, HOLD: begin
                // The index seen during the commit cycle already follows the hold rules.
                if (idx_in == LAST_IDX) begin
                    state_nxt = HOLD;
                end else if (idx_in == '0) begin
                    state_nxt = IDLE;
                end else if (idx_in == ONE_IDX) begin
                    cap_en       = 1'b1;
                    expected_nxt = TWO_IDX;
                    state_nxt    = FIRST_NXT;
                end else begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign commit = (state_nxt == COMMIT);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= IDLE;
            expected <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            expected <= expected_nxt;
            busy     <= (state_nxt == CAPTURE) || (state_nxt == COMMIT);
        end
    end

    // Shadow capture; the bank is loaded on the edge entering COMMIT so it is valid with the pulse.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int unsigned j = 0; j < N_NOTES; j++) begin
                shadow[j] <= '0;
            end
            x_bank      <= '0;
            frame_valid <= 1'b0;
            seq_err     <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_valid <= commit;
            if (err_set) begin
                seq_err <= 1'b1;
            end
            for (int unsigned j = 0; j < N_NOTES; j++) begin
                if (cap_en && (cap_slot == IDX_W'(j))) begin
                    shadow[j] <= x_in;
                end
            end
            if (commit) begin
                frame_cnt <= frame_cnt + 8'd1;
                for (int unsigned j = 0; j < N_NOTES; j++) begin
                    x_bank[j*W +: W] <= (j == N_NOTES - 1) ? x_in : shadow[j];
                end
            end
        end
    end

`ifdef NOTE_MINMAX_EN
    logic [W-1:0] run_min, run_max, min_nxt, max_nxt;

    // Running extremes; slot 0 restarts them.
    always_comb begin
        min_nxt = run_min;
        max_nxt = run_max;
        if (cap_en) begin
            if (cap_slot == '0) begin
                min_nxt = x_in;
                max_nxt = x_in;
            end else begin
                if (x_in < run_min) min_nxt = x_in;
                if (x_in > run_max) max_nxt = x_in;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            run_min <= '0;
            run_max <= '0;
            x_min   <= '0;
            x_max   <= '0;
        end else begin
            run_min <= min_nxt;
            run_max <= max_nxt;
            if (commit) begin
                x_min <= min_nxt;
                x_max <= max_nxt;
            end
        end
    end
`else
    assign x_min = '0;
    assign x_max = '0;
`endif

endmodule

// File: tb/tb_note_stream_collector.sv
// Directed self-checking bench for note_stream_collector (default 32 slots x 10 bits).
module tb_note_stream_collector;

    localparam int unsigned N  = 32;
    localparam int unsigned W  = 10;
    localparam int unsigned IW = 6;

    logic           clk_in = 1'b0;
    logic           rst    = 1'b1;
    logic [W-1:0]   x_in   = '0;
    logic [IW-1:0]  idx_in = '0;
    logic [N*W-1:0] x_bank;
    logic           frame_valid;
    logic           busy;
    logic           seq_err;
    logic [7:0]     frame_cnt;
    logic [W-1:0]   x_min;
    logic [W-1:0]   x_max;

    int total  = 0;
    int bad    = 0;
    int pulses = 0;
    int p0     = 0;

    note_stream_collector #(.N_NOTES(N), .W(W), .IDX_W(IW)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .x_in        (x_in),
        .idx_in      (idx_in),
        .x_bank      (x_bank),
        .frame_valid (frame_valid),
        .busy        (busy),
        .seq_err     (seq_err),
        .frame_cnt   (frame_cnt),
        .x_min       (x_min),
        .x_max       (x_max)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) if (frame_valid) pulses++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] slot(input int j);
        return 64'(x_bank[j*W +: W]);
    endfunction

    task automatic send(input int idx, input int x);
        idx_in = IW'(idx);
        x_in   = W'(x);
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        send(0, 0);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        send(0, 0);
        rst = 1'b0;
        check("rst_fv", 64'(frame_valid), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_err", 64'(seq_err), 0);
        check("rst_cnt", 64'(frame_cnt), 0);
        check("rst_bank", 64'(|x_bank), 0);
        check("rst_min", 64'(x_min), 0);
        check("rst_max", 64'(x_max), 0);

        // Full frame, slot k = 10k+5
        do_reset();
        p0 = pulses;
        send(0, 0);
        send(1, 5);
        check("ff_busy1", 64'(busy), 1);
        check("ff_fv_early", 64'(frame_valid), 0);
        for (int k = 2; k <= 31; k++) send(k, 10*(k-1) + 5);
        send(32, 315);
        check("ff_fv", 64'(frame_valid), 1);
        check("ff_busy_commit", 64'(busy), 1);
        check("ff_cnt", 64'(frame_cnt), 1);
        check("ff_s0", slot(0), 5);
        check("ff_s15", slot(15), 155);
        check("ff_s31", slot(31), 315);
`ifdef NOTE_MINMAX_EN
        check("ff_min", 64'(x_min), 5);
        check("ff_max", 64'(x_max), 315);
`else
        check("ff_min", 64'(x_min), 0);
        check("ff_max", 64'(x_max), 0);
`endif
        send(32, 0);
        check("ff_fv_drop", 64'(frame_valid), 0);
        check("ff_busy_hold", 64'(busy), 0);
        check("ff_s31_hold", slot(31), 315);
        send(32, 0);
        check("ff_pulses", 64'(pulses - p0), 1);
        check("ff_err", 64'(seq_err), 0);
        send(40, 0);
        check("hold_over_err", 64'(seq_err), 1);
        check("hold_over_busy", 64'(busy), 0);

        // Back-to-back frames
        do_reset();
        p0 = pulses;
        for (int k = 1; k <= 32; k++) send(k, 100);
        check("bb_a_fv", 64'(frame_valid), 1);
        check("bb_a_s0", slot(0), 100);
        for (int i = 0; i < 3; i++) send(32, 0);
        send(0, 0);
        for (int k = 1; k <= 32; k++) begin
            send(k, 1000 - (k-1));
            if (k == 16) check("bb_a_held", slot(31), 100);
        end
        check("bb_b_fv", 64'(frame_valid), 1);
        check("bb_b_s0", slot(0), 1000);
        check("bb_b_s31", slot(31), 969);
        check("bb_cnt", 64'(frame_cnt), 2);
        send(0, 0);
        check("bb_pulses", 64'(pulses - p0), 2);

        // Out-of-order index; idx above N in IDLE is ignored
        do_reset();
        p0 = pulses;
        send(40, 0);
        check("idle_over_err", 64'(seq_err), 0);
        check("idle_over_busy", 64'(busy), 0);
        for (int k = 1; k <= 10; k++) send(k, k);
        send(12, 12);
        check("ooo_err", 64'(seq_err), 1);
        check("ooo_busy", 64'(busy), 0);
        send(0, 0);
        check("ooo_err_sticky", 64'(seq_err), 1);
        check("ooo_bank", 64'(|x_bank), 0);
        check("ooo_pulses", 64'(pulses - p0), 0);
        for (int k = 1; k <= 32; k++) send(k, 3*k);
        check("ooo_clean_fv", 64'(frame_valid), 1);
        check("ooo_clean_cnt", 64'(frame_cnt), 1);
        check("ooo_clean_s9", slot(9), 30);
        check("ooo_clean_err", 64'(seq_err), 1);

        // Sender reset mid-frame
        do_reset();
        p0 = pulses;
        for (int k = 1; k <= 15; k++) send(k, 500);
        send(0, 0);
        check("sr_busy", 64'(busy), 0);
        for (int k = 1; k <= 32; k++) send(k, 7);
        send(32, 0);
        check("sr_err", 64'(seq_err), 0);
        check("sr_pulses", 64'(pulses - p0), 1);
        for (int j = 0; j < 32; j++) check($sformatf("sr_s%0d", j), slot(j), 7);
`ifdef NOTE_MINMAX_EN
        check("sr_min", 64'(x_min), 7);
        check("sr_max", 64'(x_max), 7);
`endif

        // Local reset mid-capture
        do_reset();
        for (int k = 1; k <= 32; k++) send(k, 9);
        send(0, 0);
        check("lr_pre_bank", slot(4), 9);
        for (int k = 1; k <= 19; k++) send(k, k);
        check("lr_busy_pre", 64'(busy), 1);
        rst = 1'b1;
        send(20, 20);
        rst = 1'b0;
        check("lr_fv", 64'(frame_valid), 0);
        check("lr_busy", 64'(busy), 0);
        check("lr_err", 64'(seq_err), 0);
        check("lr_cnt", 64'(frame_cnt), 0);
        check("lr_bank", 64'(|x_bank), 0);
        p0 = pulses;
        for (int k = 21; k <= 32; k++) send(k, k);
        send(32, 0);
        check("lr_after_busy", 64'(busy), 0);
        check("lr_after_bank", 64'(|x_bank), 0);
        check("lr_after_cnt", 64'(frame_cnt), 0);
        check("lr_after_pulses", 64'(pulses - p0), 0);
        check("lr_after_err", 64'(seq_err), 0);

        // Counter wrap over 256 back-to-back frames
        do_reset();
        p0 = pulses;
        for (int f = 0; f < 256; f++) begin
            for (int k = 1; k <= 32; k++) send(k, f);
            if (f == 254) check("wrap_cnt255", 64'(frame_cnt), 255);
        end
        check("wrap_fv", 64'(frame_valid), 1);
        check("wrap_cnt0", 64'(frame_cnt), 0);
        check("wrap_s0", slot(0), 255);
        send(0, 0);
        check("wrap_pulses", 64'(pulses - p0), 256);
        check("wrap_err", 64'(seq_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
